// File: rtl/aes32dsi_round_seq.sv
// aes32dsi_round_seq
//   Multi-cycle sequencer that computes one full AES final decryption round
//   (InvShiftRows, InvSubBytes, AddRoundKey) on a 128-bit state. It issues
//   sixteen aes32dsi byte-steps, spread over NLANES datapath instances. Each
//   step's result is chained into the next step's rs1.
//
//   Parameters:
//     NLANES     - number of aes32dsi instances working in parallel (1, 2 or 4)
//
//   Ports:
//     clk        - clock, all state updates on the rising edge
//     rst        - asynchronous active-high reset
//     in_valid   - request carries a valid state/key pair
//     in_ready   - block can accept a request (IDLE only)
//     state_in   - ciphertext-side state, word i = state_in[32*i+31:32*i]
//     rkey_in    - round key, word j = rkey_in[32*j+31:32*j]
//     abort      - cancels the operation in flight
//     out_valid  - state_out holds a completed result
//     out_ready  - consumer accepts the result
//     state_out  - result, word j = state_out[32*j+31:32*j]
//     busy       - sequencer is not IDLE
module aes32dsi_round_seq #(
    parameter int NLANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] rkey_in,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if ((NLANES != 1) && (NLANES != 2) && (NLANES != 4)) begin : g_bad_nlanes
        $fatal(1, "aes32dsi_round_seq: NLANES must be 1, 2 or 4");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index of the last step; the counter never goes past it.
    localparam logic [3:0] LAST_STEP   = 4'(16 / NLANES - 1);
    // Word distance between successive words handled by one lane.
    localparam logic [1:0] LANE_STRIDE = 2'(NLANES % 4);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        // Byte b sits at bit offset 8*(255-b), and 255-b equals ~b.
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    // bs=k takes byte lane 3-k of rs2, substitutes it, and puts it back in the
    // same lane before folding it into rs1.
    function automatic logic [31:0] aes32dsi(input logic [31:0] rs1,
                                             input logic [31:0] rs2,
                                             input logic [1:0]  bs);
        logic [1:0] lane;
        logic [7:0] sb;
        lane = 2'd3 - bs;
        sb   = inv_sbox(rs2[{lane, 3'b000} +: 8]);
        return rs1 ^ ({24'd0, sb} << {lane, 3'b000});
    endfunction

    logic [1:0]               fsm_r;
    logic [3:0]               cnt_r;
    logic [3:0][31:0]         s_r;
    logic [3:0][31:0]         key_r;
    logic [NLANES-1:0][31:0]  acc_r;
    logic [3:0][31:0]         res_r;
    logic [127:0]             state_out_r;

    logic [1:0]               k_s;
    logic                     last_s;
    logic [NLANES-1:0][1:0]   word_s;
    logic [NLANES-1:0][1:0]   src_s;
    logic [NLANES-1:0][31:0]  step_s;
    logic [NLANES-1:0][31:0]  acc_next_s;
    logic [3:0][31:0]         res_next_s;

    // One byte-step per lane: pick the word each lane works on and its source word.
    always_comb begin
        k_s        = cnt_r[1:0];
        last_s     = (cnt_r == LAST_STEP);
        res_next_s = res_r;
        word_s     = '0;
        src_s      = '0;
        step_s     = '0;
        acc_next_s = '0;
        for (int n = 0; n < NLANES; n++) begin
            word_s[n] = 2'(int'(cnt_r[3:2]) * NLANES + n);
            // InvShiftRows: step k of word j reads state word (j-k) mod 4.
            src_s[n]  = word_s[n] - k_s;
            step_s[n] = aes32dsi(acc_r[n], s_r[src_s[n]], k_s);
            if (k_s == 2'd3) begin
                // Word finished: bank it and seed the accumulator for the next group.
                res_next_s[word_s[n]] = step_s[n];
                acc_next_s[n]         = key_r[word_s[n] + LANE_STRIDE];
            end else begin
                acc_next_s[n] = step_s[n];
            end
        end
    end

    // Sequencer state, operand capture and accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= ST_IDLE;
            cnt_r       <= 4'd0;
            s_r         <= '0;
            key_r       <= '0;
            acc_r       <= '0;
            res_r       <= '0;
            state_out_r <= 128'd0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_r   <= state_in;
                        key_r <= rkey_in;
                        for (int n = 0; n < NLANES; n++) begin
                            acc_r[n] <= rkey_in[32*n +: 32];
                        end
                        cnt_r <= 4'd0;
                        fsm_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (abort) begin
                        cnt_r <= 4'd0;
                        fsm_r <= ST_IDLE;
                    end else begin
                        acc_r <= acc_next_s;
                        res_r <= res_next_s;
                        if (last_s) begin
                            state_out_r <= res_next_s;
                            cnt_r       <= 4'd0;
                            fsm_r       <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // abort and out_ready both release the result; abort just drops it.
                    if (abort || out_ready) begin
                        fsm_r <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                    fsm_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (fsm_r == ST_IDLE);
    assign out_valid = (fsm_r == ST_DONE);
    assign busy      = (fsm_r != ST_IDLE);
    assign state_out = state_out_r;

endmodule

// File: tb/tb_aes32dsi_round_seq.sv
// Testbench for aes32dsi_round_seq. Three instances (NLANES = 1, 2, 4) share
// clock, reset and operand buses; each has its own handshake signals.
module tb_aes32dsi_round_seq;

    logic         clk;
    logic         rst;
    logic [127:0] state_in;
    logic [127:0] rkey_in;
    logic [2:0]   iv;
    logic [2:0]   ir;
    logic [2:0]   abt;
    logic [2:0]   ov;
    logic [2:0]   ordy;
    logic [2:0]   bz;
    logic [127:0] so [3];

    int n_checks;
    int n_fail;

    logic [7:0] isb [256];

    aes32dsi_round_seq #(.NLANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .state_in(state_in), .rkey_in(rkey_in), .abort(abt[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(so[0]), .busy(bz[0])
    );

    aes32dsi_round_seq #(.NLANES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .state_in(state_in), .rkey_in(rkey_in), .abort(abt[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(so[1]), .busy(bz[1])
    );

    aes32dsi_round_seq #(.NLANES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .state_in(state_in), .rkey_in(rkey_in), .abort(abt[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(so[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Inverse S-box derived from the GF(2^8) definition of the forward S-box.
    task automatic build_model();
        logic [7:0] xv, inv, sv;
        for (int x = 0; x < 256; x++) begin
            xv  = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sv = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            isb[sv] = xv;
        end
    endtask

    function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] key);
        logic [127:0] r;
        logic [31:0]  acc, w;
        logic [7:0]   b;
        int           src, sh;
        r = 128'd0;
        for (int j = 0; j < 4; j++) begin
            acc = key[32*j +: 32];
            for (int k = 0; k < 4; k++) begin
                src = (j - k + 4) % 4;
                w   = s[32*src +: 32];
                sh  = 8 * (3 - k);
                b   = w[sh +: 8];
                acc = acc ^ ({24'd0, isb[b]} << sh);
            end
            r[32*j +: 32] = acc;
        end
        return r;
    endfunction

    // Issue one request to instance d, wait for its result, then hand it off.
    task automatic do_round(input int d, input logic [127:0] s, input logic [127:0] key,
                            output logic [127:0] res, output int lat);
        @(negedge clk);
        state_in = s;
        rkey_in  = key;
        iv[d]    = 1'b1;
        @(negedge clk);
        iv[d] = 1'b0;
        lat   = 0;
        while (ov[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res     = so[d];
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: in_ready=%b out_valid=%b busy=%b, want 1 0 0", d, ir[d], ov[d], bz[d]);
            end
            n_checks++;
            if (so[d] !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_state_out[%0d]: got %h want 0", d, so[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [127:0] res;
        int           lat;
        do_round(0, 128'd0, 128'd0, res, lat);
        n_checks++;
        if (res !== {16{8'h52}}) begin
            n_fail++;
            $display("FAIL zero_result: got %h want %h", res, {16{8'h52}});
        end
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d want 16", lat);
        end
        n_checks++;
        if (ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_handoff: in_ready=%b busy=%b want 1 0", ir[0], bz[0]);
        end
    endtask

    task automatic test_lanes_key_ff();
        logic [127:0] res;
        int           lat;
        for (int d = 0; d < 3; d++) begin
            do_round(d, 128'd0, {128{1'b1}}, res, lat);
            n_checks++;
            if (res !== {16{8'hAD}}) begin
                n_fail++;
                $display("FAIL keyff_result[%0d]: got %h want %h", d, res, {16{8'hAD}});
            end
            n_checks++;
            if (lat !== (16 >> d)) begin
                n_fail++;
                $display("FAIL keyff_latency[%0d]: got %0d want %0d", d, lat, 16 >> d);
            end
        end
    endtask

    // 0x63 inverts to 0x00; byte b of word w lands in byte b of word (w+3-b)%4.
    task automatic test_walk();
        logic [127:0] s, exp, res;
        int           lat, j;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                s = 128'd0;
                s[32*w + 8*b +: 8] = 8'h63;
                exp = {16{8'h52}};
                j = (w + 3 - b) % 4;
                exp[32*j + 8*b +: 8] = 8'h00;
                do_round((w + b) % 3, s, 128'd0, res, lat);
                n_checks++;
                if (res !== exp) begin
                    n_fail++;
                    $display("FAIL walk_w%0d_b%0d: got %h want %h", w, b, res, exp);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] key, exp;
        int           cyc;
        key = 128'h0123456789abcdef_fedcba9876543210;
        exp = key ^ {16{8'h52}};
        @(negedge clk);
        state_in = 128'd0;
        rkey_in  = key;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        cyc   = 0;
        while (ov[0] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (so[0] !== exp) begin
            n_fail++;
            $display("FAIL bp_result: got %h want %h", so[0], exp);
        end
        for (int i = 0; i < 10; i++) begin
            iv[0]    = i[0];
            state_in = {$urandom, $urandom, $urandom, $urandom};
            rkey_in  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n_checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || so[0] !== exp) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b state_out=%h want 1 0 %h", i, ov[0], ir[0], so[0], exp);
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0", ov[0], ir[0], bz[0]);
        end
    endtask

    task automatic test_abort();
        logic [127:0] prev, res;
        int           lat;
        logic         seen;
        prev = so[0];
        @(negedge clk);
        state_in = 128'h11223344_55667788_99aabbcc_ddeeff00;
        rkey_in  = 128'h0;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (6) @(negedge clk);
        abt[0] = 1'b1;
        @(negedge clk);
        abt[0] = 1'b0;
        n_checks++;
        if (ir[0] !== 1'b1 || bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_calc_idle: in_ready=%b busy=%b out_valid=%b want 1 0 0", ir[0], bz[0], ov[0]);
        end
        n_checks++;
        if (so[0] !== prev) begin
            n_fail++;
            $display("FAIL abort_state_out_kept: got %h want %h", so[0], prev);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_out_valid: out_valid rose after abort (got %b want 0)", seen);
        end
        do_round(0, 128'd0, 128'd0, res, lat);
        n_checks++;
        if (res !== {16{8'h52}} || lat !== 16) begin
            n_fail++;
            $display("FAIL abort_next_round: got %h lat %0d want %h lat 16", res, lat, {16{8'h52}});
        end
        // abort together with out_ready in DONE drops the result
        @(negedge clk);
        state_in = 128'd0;
        rkey_in  = 128'd0;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        lat   = 0;
        while (ov[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        abt[0]  = 1'b1;
        ordy[0] = 1'b1;
        @(negedge clk);
        abt[0]  = 1'b0;
        ordy[0] = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || lat !== 16) begin
            n_fail++;
            $display("FAIL abort_done: out_valid=%b in_ready=%b lat=%0d want 0 1 16", ov[0], ir[0], lat);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        @(negedge clk);
        state_in = 128'd0;
        rkey_in  = 128'hdeadbeef_00000000_cafef00d_12345678;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_flags: in_ready=%b out_valid=%b busy=%b want 1 0 0", ir[0], ov[0], bz[0]);
        end
        n_checks++;
        if (so[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL async_rst_state_out: got %h want 0", so[0]);
        end
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0] !== 1'b0 || bz[0] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_no_partial: activity after reset (got %b want 0)", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] s, key, exp, res;
        int           lat, d;
        for (int i = 0; i < 1000; i++) begin
            d   = i % 3;
            s   = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            exp = model_round(s, key);
            do_round(d, s, key, res, lat);
            n_checks++;
            if (res !== exp || lat !== (16 >> d)) begin
                n_fail++;
                $display("FAIL b2b_%0d[lanes%0d]: got %h lat %0d want %h lat %0d", i, 1 << d, res, lat, exp, 16 >> d);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        iv       = 3'b000;
        abt      = 3'b000;
        ordy     = 3'b000;
        state_in = 128'd0;
        rkey_in  = 128'd0;
        build_model();
        test_reset();
        test_zero();
        test_lanes_key_ff();
        test_walk();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
